sine_ref_gen: RTL and testbench
===============================

Name: sine_ref_gen

Overview:
Upstream reference source for the PWM accelerator. A DDS phase accumulator advances once per carrier sync pulse. It looks up a quarter-wave sine ROM, scales the sample by the modulation index and emits a signed 16-bit reference sample with a valid strobe. The strobe feeds the accelerator's reference input, so the modulation waveform updates exactly once per carrier period.

Parameters:
PHASE_WIDTH, 32, phase accumulator and frequency word width.
LUT_ADDR_WIDTH, 8, quarter-wave ROM address width (256 entries).
DATA_WIDTH, 16, signed output sample width.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
enable  in  1  generator enable.
sync  in  1  one-cycle carrier sync pulse; each pulse requests one sample.
freq_word  in  PHASE_WIDTH  phase increment per sync.
mod_index  in  16  unsigned Q0.16 amplitude scale.
ref_out  out  DATA_WIDTH  signed reference sample.
ref_valid  out  1  one-cycle strobe marking a new ref_out.
zero_cross  out  1  one-cycle strobe, coincident with ref_valid, on the first sample of each cycle.
phase_out  out  PHASE_WIDTH  current accumulator value.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n). rst_n=0 clears acc, the pipeline valids, ref_out, ref_valid, zero_cross and phase_out to 0 on the next edge. A reset mid-pipeline drops in-flight samples; no late strobe is issued.
- Accumulator: on a cycle with enable=1 and sync=1, the current acc is captured into stage 0, then acc <= acc + freq_word (modulo 2^PHASE_WIDTH, wrap silent). The sample therefore uses the phase before the increment. The first sample after enable uses phase 0.
- Phase decode: quad = acc[MSB:MSB-1]; idx = next LUT_ADDR_WIDTH bits; lower bits are ignored (no interpolation).
- Mirroring: quad 1 and 3 use ~idx. Quad 2 and 3 negate the result.
- ROM contents: entry i = round(32767*sin((i+0.5)*pi/(2*2^LUT_ADDR_WIDTH))). The range is 101..32767, and the half-step offset makes the waveform symmetric with no duplicated peak.
- Pipeline: S0 captures quad/idx. S1 registers the ROM read. S2 computes prod = lut*mod_index (32-bit unsigned), keeps mag = prod[31:16] (≤32766), then applies the sign. ref_out and ref_valid are registered from S2.
- Latency: 3 cycles from sync to ref_valid. The pipeline accepts one sync per cycle, including back-to-back.
- Hold behaviour: ref_out holds its value between strobes.
- zero_cross: asserted with the ref_valid of a sample whose phase is in quad 0 while the previous emitted sample's phase was in quad 3. The first sample after enable also asserts it.
- Disable: enable=0 sets acc to 0, clears the pipeline valids and sets ref_out to 0 on the next edge. A sync arriving while disabled is ignored.
- Simultaneous events: enable falling on the same cycle as sync discards that sync. A freq_word change takes effect at the next sync. mod_index is sampled at S2.
- phase_out is a registered copy of acc.

Optional Feature:
SINE_PHASE_OFFSET_EN.
- Defined: adds a port phase_offset in 16, zero-extended to the accumulator MSBs (offset << (PHASE_WIDTH-16)). The lookup phase becomes acc + offset; the accumulator itself is unaffected. zero_cross uses the offset phase. This supports 120° leg offsets.
- Undefined: the port is absent and the lookup phase equals acc.

Decomposition:
- Package sine_ref_pkg: LUT_DEPTH, quadrant encodings (Q0..Q3), SAMPLE_MAX=32767, and the mag/sign helper width constants.
- One sub-module, sine_quarter_lut: a registered synchronous ROM with addr in and data out, 1-cycle latency, initialised from a generated table.

Test Plan:
- Reset: hold rst_n=0 with sync pulsing -> ref_out=0, ref_valid=0, phase_out=0. After release, no strobe until the first enabled sync.
- Quadrant sweep: freq_word=0x40000000, mod_index=0xFFFF, 4 syncs -> ref_out = +100, +32766, -100, -32766. zero_cross on the 1st strobe only. Each ref_valid arrives exactly 3 cycles after its sync.
- Scaling: same sweep with mod_index=0x8000 -> +50, +16383, -50, -16383. With mod_index=0 -> all 0.
- Wrap and 50 Hz: freq_word=0x028F5C29, 100 syncs -> exactly one zero_cross. phase_out after 100 syncs = 0x00000004 (modulo wrap).
- Back-to-back and disable: syncs on 3 consecutive cycles -> 3 consecutive ref_valid strobes. Dropping enable mid-stream -> no further strobes, ref_out=0 next cycle, and the next enabled sample starts at phase 0.
- SINE_PHASE_OFFSET_EN: phase_offset=0x4000, freq_word=0 -> every sample = +32766.

Source files
------------

// File: rtl/sine_ref_pkg.sv
// Shared constants, quadrant encodings and the quarter-wave table
// generator for the sine reference generator.
package sine_ref_pkg;

    localparam int LUT_AW     = 8;
    localparam int LUT_DEPTH  = 1 << LUT_AW;
    localparam int SAMPLE_MAX = 32767;
    localparam int MAG_W      = 16;
    localparam int PROD_W     = 32;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // Half-step sampling keeps the quarter wave symmetric with no
    // repeated peak entry.
    function automatic int lut_entry(input int i, input int depth);
        real ang;
        ang = (real'(i) + 0.5) * 3.14159265358979323846
              / (2.0 * real'(depth));
        return $rtoi(real'(SAMPLE_MAX) * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/sine_ref_if.sv
// Control / sample bundle between the PWM sequencer and the reference
// generator. Optional port phase_offset under SINE_PHASE_OFFSET_EN.
interface sine_ref_if #(
    parameter int PW = 32,
    parameter int DW = 16
);
    logic          enable;
    logic          sync;
    logic [PW-1:0] freq_word;
    logic [15:0]   mod_index;
`ifdef SINE_PHASE_OFFSET_EN
    logic [15:0]   phase_offset;
`endif
    logic [DW-1:0] ref_out;
    logic          ref_valid;
    logic          zero_cross;
    logic [PW-1:0] phase_out;

`ifdef SINE_PHASE_OFFSET_EN
    modport master (
        output enable, sync, freq_word, mod_index, phase_offset,
        input  ref_out, ref_valid, zero_cross, phase_out
    );
    modport slave (
        input  enable, sync, freq_word, mod_index, phase_offset,
        output ref_out, ref_valid, zero_cross, phase_out
    );
`else
    modport master (
        output enable, sync, freq_word, mod_index,
        input  ref_out, ref_valid, zero_cross, phase_out
    );
    modport slave (
        input  enable, sync, freq_word, mod_index,
        output ref_out, ref_valid, zero_cross, phase_out
    );
`endif

endinterface

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave sine ROM, one cycle read latency.
// Ports: clk, addr (LUT_ADDR_WIDTH), data (DATA_WIDTH).
module sine_quarter_lut
    import sine_ref_pkg::*;
#(
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic [LUT_ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0]     data
);

    localparam int DEPTH = 1 << LUT_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rom [DEPTH];
    logic [DATA_WIDTH-1:0] data_d, data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] VAL =
            DATA_WIDTH'(lut_entry(i, DEPTH));
        assign rom[i] = VAL;
    end

    always_comb begin
        data_d = rom[addr];
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/sine_ref_gen.sv
// DDS sine reference: phase accumulator stepped per carrier sync,
// quarter-wave lookup, Q0.16 amplitude scaling, 3-cycle latency.
// Ports: clk, rst_n (sync, active-low), bus (sine_ref_if.slave).
// Build option: SINE_PHASE_OFFSET_EN adds phase_offset to lookups.
module sine_ref_gen
    import sine_ref_pkg::*;
#(
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 16
) (
    input logic      clk,
    input logic      rst_n,
    sine_ref_if.slave bus
);

    localparam int TOP_W = 2 + LUT_ADDR_WIDTH;

    logic [PHASE_WIDTH-1:0]    acc_d, acc_q;
    logic [PHASE_WIDTH-1:0]    phase_d, phase_q;
    logic                      s0_valid_d, s0_valid_q;
    quad_e                     s0_quad_d, s0_quad_q;
    logic [LUT_ADDR_WIDTH-1:0] s0_idx_d, s0_idx_q;
    logic                      s1_valid_d, s1_valid_q;
    quad_e                     s1_quad_d, s1_quad_q;
    logic [DATA_WIDTH-1:0]     ref_d, ref_q;
    logic                      ref_valid_d, ref_valid_q;
    logic                      zc_d, zc_q;
    logic                      first_d, first_q;
    quad_e                     last_quad_d, last_quad_q;

    logic [PHASE_WIDTH-1:0]    lk_phase;
    logic [TOP_W-1:0]          lk_top;
    logic [LUT_ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]     lut_data;
    logic [PROD_W-1:0]         prod;
    logic [MAG_W-1:0]          mag;

    // Odd quadrants walk the quarter wave backwards.
    always_comb begin
        rom_addr = s0_quad_q[0] ? ~s0_idx_q : s0_idx_q;
    end

    sine_quarter_lut #(
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_lut (
        .clk  (clk),
        .addr (rom_addr),
        .data (lut_data)
    );

    always_comb begin
`ifdef SINE_PHASE_OFFSET_EN
        lk_phase = acc_q
                 + {bus.phase_offset, {(PHASE_WIDTH-16){1'b0}}};
`else
        lk_phase = acc_q;
`endif
        lk_top = TOP_W'(lk_phase >> (PHASE_WIDTH - TOP_W));
        prod   = PROD_W'(lut_data) * PROD_W'(bus.mod_index);
        mag    = MAG_W'(prod >> MAG_W);
    end

    always_comb begin
        acc_d       = acc_q;
        phase_d     = acc_q;
        s0_valid_d  = 1'b0;
        s0_quad_d   = s0_quad_q;
        s0_idx_d    = s0_idx_q;
        s1_valid_d  = s0_valid_q;
        s1_quad_d   = s0_quad_q;
        ref_d       = ref_q;
        ref_valid_d = 1'b0;
        zc_d        = 1'b0;
        first_d     = first_q;
        last_quad_d = last_quad_q;
        if (!bus.enable) begin
            acc_d      = '0;
            s1_valid_d = 1'b0;
            ref_d      = '0;
            first_d    = 1'b1;
        end else begin
            if (bus.sync) begin
                s0_valid_d = 1'b1;
                s0_quad_d  = quad_e'(lk_top[TOP_W-1 -: 2]);
                s0_idx_d   = lk_top[LUT_ADDR_WIDTH-1:0];
                acc_d      = acc_q + bus.freq_word;
            end
            if (s1_valid_q) begin
                ref_valid_d = 1'b1;
                if (s1_quad_q[1])
                    ref_d = DATA_WIDTH'(-$signed({1'b0, mag}));
                else
                    ref_d = DATA_WIDTH'(mag);
                zc_d = first_q
                    || (s1_quad_q == Q0 && last_quad_q == Q3);
                first_d     = 1'b0;
                last_quad_d = s1_quad_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            phase_q     <= '0;
            s0_valid_q  <= 1'b0;
            s0_quad_q   <= Q0;
            s0_idx_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_quad_q   <= Q0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            zc_q        <= 1'b0;
            first_q     <= 1'b1;
            last_quad_q <= Q0;
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            s0_valid_q  <= s0_valid_d;
            s0_quad_q   <= s0_quad_d;
            s0_idx_q    <= s0_idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_quad_q   <= s1_quad_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            zc_q        <= zc_d;
            first_q     <= first_d;
            last_quad_q <= last_quad_d;
        end
    end

    assign bus.ref_out    = ref_q;
    assign bus.ref_valid  = ref_valid_q;
    assign bus.zero_cross = zc_q;
    assign bus.phase_out  = phase_q;

endmodule

// File: tb/tb_sine_ref_gen.sv
// Directed bench for sine_ref_gen: reset, quadrant sweep, scaling,
// wrap, back-to-back, disable and the optional phase offset.
module tb_sine_ref_gen;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sine_ref_if #(.PW(32), .DW(16)) bus ();

    sine_ref_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated sync; strobe must appear exactly 3 cycles later.
    task automatic sample(input string tag,
                          input logic signed [15:0] exp,
                          input logic exp_zc);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        chk({tag, "_v1"}, 32'(bus.ref_valid), 32'd0);
        tick();
        chk({tag, "_v2"}, 32'(bus.ref_valid), 32'd0);
        tick();
        chk({tag, "_v3"}, 32'(bus.ref_valid), 32'd1);
        chk({tag, "_ref"}, 32'($signed(bus.ref_out)), 32'(exp));
        chk({tag, "_zc"}, 32'(bus.zero_cross), 32'(exp_zc));
        tick();
        chk({tag, "_v4"}, 32'(bus.ref_valid), 32'd0);
        chk({tag, "_hold"}, 32'($signed(bus.ref_out)), 32'(exp));
    endtask

    initial begin
        int nv;
        int nz;
        rst_n         = 1'b0;
        bus.enable    = 1'b1;
        bus.sync      = 1'b0;
        bus.freq_word = 32'h4000_0000;
        bus.mod_index = 16'hFFFF;
`ifdef SINE_PHASE_OFFSET_EN
        bus.phase_offset = 16'h0000;
`endif
        // reset with sync pulsing
        for (int i = 0; i < 4; i++) begin
            bus.sync = ~bus.sync;
            tick();
        end
        chk("rst_valid", 32'(bus.ref_valid), 32'd0);
        chk("rst_ref", 32'(bus.ref_out), 32'd0);
        chk("rst_phase", bus.phase_out, 32'd0);
        chk("rst_zc", 32'(bus.zero_cross), 32'd0);
        rst_n    = 1'b1;
        bus.sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_valid", 32'(bus.ref_valid), 32'd0);
        end
        chk("idle_phase", bus.phase_out, 32'd0);

        // quadrant sweep, full scale
        sample("q0", 16'sd100, 1'b1);
        chk("phase_q1", bus.phase_out, 32'h4000_0000);
        sample("q1", 16'sd32766, 1'b0);
        sample("q2", -16'sd100, 1'b0);
        sample("q3", -16'sd32766, 1'b0);

        // half scale, continuing across the wrap
        bus.mod_index = 16'h8000;
        sample("h0", 16'sd50, 1'b1);
        sample("h1", 16'sd16383, 1'b0);
        sample("h2", -16'sd50, 1'b0);
        sample("h3", -16'sd16383, 1'b0);

        // zero scale
        bus.mod_index = 16'h0000;
        sample("z0", 16'sd0, 1'b1);
        sample("z1", 16'sd0, 1'b0);
        sample("z2", 16'sd0, 1'b0);
        sample("z3", 16'sd0, 1'b0);

        // 50 Hz word, 100 back-to-back syncs
        bus.mod_index = 16'hFFFF;
        bus.enable    = 1'b0;
        tick();
        bus.enable    = 1'b1;
        bus.freq_word = 32'h028F_5C29;
        nv = 0;
        nz = 0;
        for (int i = 0; i < 104; i++) begin
            bus.sync = (i < 100);
            tick();
            if (bus.ref_valid === 1'b1) nv++;
            if (bus.zero_cross === 1'b1) nz++;
        end
        chk("wrap_nvalid", 32'(nv), 32'd100);
        chk("wrap_nzc", 32'(nz), 32'd1);
        chk("wrap_phase", bus.phase_out, 32'h0000_0004);

        // disable clears state
        bus.enable = 1'b0;
        tick();
        chk("dis_ref", 32'(bus.ref_out), 32'd0);
        tick();
        chk("dis_phase", bus.phase_out, 32'd0);
        bus.enable    = 1'b1;
        bus.freq_word = 32'h4000_0000;

        // back-to-back syncs
        bus.sync = 1'b1;
        tick();
        tick();
        tick();
        bus.sync = 1'b0;
        chk("b2b_v0", 32'(bus.ref_valid), 32'd1);
        chk("b2b_r0", 32'($signed(bus.ref_out)), 32'(16'sd100));
        chk("b2b_z0", 32'(bus.zero_cross), 32'd1);
        tick();
        chk("b2b_v1", 32'(bus.ref_valid), 32'd1);
        chk("b2b_r1", 32'($signed(bus.ref_out)), 32'(16'sd32766));
        tick();
        chk("b2b_v2", 32'(bus.ref_valid), 32'd1);
        chk("b2b_r2", 32'($signed(bus.ref_out)), 32'(-16'sd100));
        tick();
        chk("b2b_v3", 32'(bus.ref_valid), 32'd0);

        // drop enable mid-stream
        bus.sync = 1'b1;
        tick();
        tick();
        bus.enable = 1'b0;
        tick();
        chk("mid_valid", 32'(bus.ref_valid), 32'd0);
        chk("mid_ref", 32'(bus.ref_out), 32'd0);
        bus.sync = 1'b0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ref_valid === 1'b1) nv++;
        end
        chk("mid_nostrobe", 32'(nv), 32'd0);
        bus.enable = 1'b1;
        sample("restart", 16'sd100, 1'b1);

`ifdef SINE_PHASE_OFFSET_EN
        bus.enable = 1'b0;
        tick();
        bus.enable       = 1'b1;
        bus.freq_word    = 32'h0000_0000;
        bus.phase_offset = 16'h4000;
        sample("off0", 16'sd32766, 1'b1);
        sample("off1", 16'sd32766, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
